// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: two-entry skid buffer with valid/ready handshake.
// Signed ADD/SUB overflow is turned into a precise exception with side effects suppressed.
module ex_mem_stage #(
    parameter int unsigned         DATA_W     = 32,
    parameter int unsigned         FUNCT_W    = 6,
    parameter int unsigned         REG_ADDR_W = 5,
    parameter logic [FUNCT_W-1:0]  FUNCT_ADD  = FUNCT_W'(6'h20),
    parameter logic [FUNCT_W-1:0]  FUNCT_SUB  = FUNCT_W'(6'h22)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [FUNCT_W-1:0]    ex_funct,
    input  logic [DATA_W-1:0]     ex_result,
    input  logic                  ex_overflow,
    input  logic [DATA_W-1:0]     ex_pc,
    input  logic                  ex_reg_we,
    input  logic [REG_ADDR_W-1:0] ex_reg_waddr,
    input  logic                  ex_mem_re,
    input  logic                  ex_mem_we,
    input  logic [DATA_W-1:0]     ex_mem_wdata,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [DATA_W-1:0]     mem_result,
    output logic [DATA_W-1:0]     mem_pc,
    output logic [DATA_W-1:0]     mem_mem_wdata,
    output logic                  mem_reg_we,
    output logic [REG_ADDR_W-1:0] mem_reg_waddr,
    output logic                  mem_mem_re,
    output logic                  mem_mem_we,
    output logic                  mem_exc_ovf,
    output logic                  exc_req,
    output logic [DATA_W-1:0]     exc_pc
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     wdata;
        logic                  reg_we;
        logic [REG_ADDR_W-1:0] reg_waddr;
        logic                  mem_re;
        logic                  mem_we;
        logic                  exc_ovf;
    } entry_t;

    state_t            r_state;
    entry_t            r_main;
    entry_t            r_skid;
    logic              r_ex_ready;
    logic              r_mem_valid;
    logic              r_exc_req;
    logic [DATA_W-1:0] r_exc_pc;

    logic   w_accept;
    logic   w_pop;
    logic   w_trap;
    entry_t w_in;
    state_t w_state_nxt;

    always_comb begin
        w_accept = ex_valid & r_ex_ready;
        w_pop    = r_mem_valid & mem_ready;
        w_trap   = ex_overflow & ((ex_funct == FUNCT_ADD) | (ex_funct == FUNCT_SUB));

        // A trapping entry keeps its payload but loses every architectural side effect.
        w_in.result    = ex_result;
        w_in.pc        = ex_pc;
        w_in.wdata     = ex_mem_wdata;
        w_in.reg_we    = ex_reg_we & ~w_trap;
        w_in.reg_waddr = ex_reg_waddr;
        w_in.mem_re    = ex_mem_re & ~w_trap;
        w_in.mem_we    = ex_mem_we & ~w_trap;
        w_in.exc_ovf   = w_trap;

        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY:   if (w_accept) w_state_nxt = ONE;
                ONE: begin
                    if (w_accept && !w_pop)      w_state_nxt = TWO;
                    else if (!w_accept && w_pop) w_state_nxt = EMPTY;
                end
                TWO:     if (w_pop) w_state_nxt = ONE;
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_ex_ready  <= 1'b1;
            r_mem_valid <= 1'b0;
            r_exc_req   <= 1'b0;
            r_exc_pc    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ex_ready  <= (w_state_nxt != TWO);
            r_mem_valid <= (w_state_nxt != EMPTY);
            r_exc_req   <= w_accept & w_trap & ~flush;
            if (w_accept && w_trap && !flush) r_exc_pc <= ex_pc;

            if (!flush) begin
                case (r_state)
                    EMPTY: if (w_accept) r_main <= w_in;
                    ONE: begin
                        if (w_accept && w_pop) r_main <= w_in;
                        else if (w_accept)     r_skid <= w_in;
                    end
                    TWO:     if (w_pop) r_main <= r_skid;
                    default: ;
                endcase
            end
        end
    end

    assign ex_ready      = r_ex_ready;
    assign mem_valid     = r_mem_valid;
    assign mem_result    = r_main.result;
    assign mem_pc        = r_main.pc;
    assign mem_mem_wdata = r_main.wdata;
    assign mem_reg_we    = r_main.reg_we;
    assign mem_reg_waddr = r_main.reg_waddr;
    assign mem_mem_re    = r_main.mem_re;
    assign mem_mem_we    = r_main.mem_we;
    assign mem_exc_ovf   = r_main.exc_ovf;
    assign exc_req       = r_exc_req;
    assign exc_pc        = r_exc_pc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: accepted entries are queued with their expected
// contents and compared against the MEM-side outputs on every falling edge.
module tb_ex_mem_stage;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] pc;
        logic [31:0] wdata;
        logic        reg_we;
        logic [4:0]  waddr;
        logic        re;
        logic        we;
        logic        exc;
    } ent_t;

    logic        clk, rst, flush;
    logic        ex_valid, ex_ready;
    logic [5:0]  ex_funct;
    logic [31:0] ex_result, ex_pc, ex_mem_wdata;
    logic        ex_overflow, ex_reg_we, ex_mem_re, ex_mem_we;
    logic [4:0]  ex_reg_waddr;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_result, mem_pc, mem_mem_wdata;
    logic        mem_reg_we, mem_mem_re, mem_mem_we, mem_exc_ovf;
    logic [4:0]  mem_reg_waddr;
    logic        exc_req;
    logic [31:0] exc_pc;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    ent_t        q[$];
    logic        exp_exc = 1'b0;
    logic [31:0] exp_exc_pc = '0;
    logic        rand_en = 1'b0;

    ex_mem_stage #(
        .DATA_W     (32),
        .FUNCT_W    (6),
        .REG_ADDR_W (5),
        .FUNCT_ADD  (F_ADD),
        .FUNCT_SUB  (F_SUB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_funct      (ex_funct),
        .ex_result     (ex_result),
        .ex_overflow   (ex_overflow),
        .ex_pc         (ex_pc),
        .ex_reg_we     (ex_reg_we),
        .ex_reg_waddr  (ex_reg_waddr),
        .ex_mem_re     (ex_mem_re),
        .ex_mem_we     (ex_mem_we),
        .ex_mem_wdata  (ex_mem_wdata),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_result    (mem_result),
        .mem_pc        (mem_pc),
        .mem_mem_wdata (mem_mem_wdata),
        .mem_reg_we    (mem_reg_we),
        .mem_reg_waddr (mem_reg_waddr),
        .mem_mem_re    (mem_mem_re),
        .mem_mem_we    (mem_mem_we),
        .mem_exc_ovf   (mem_exc_ovf),
        .exc_req       (exc_req),
        .exc_pc        (exc_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        ent_t        e;
        logic        trap;
        int unsigned sz;
        if (!rst) begin
            q.delete();
            exp_exc = 1'b0;
            check("rst_mem_valid", 32'(mem_valid), 32'd0);
            check("rst_ex_ready", 32'(ex_ready), 32'd1);
            check("rst_exc_req", 32'(exc_req), 32'd0);
        end else begin
            check("exc_req", 32'(exc_req), 32'(exp_exc));
            if (exp_exc) check("exc_pc", exc_pc, exp_exc_pc);
            sz = 32'(q.size());
            check("mem_valid", 32'(mem_valid), 32'(sz > 0));
            check("ex_ready", 32'(ex_ready), 32'(sz < 2));
            if (flush) begin
                q.delete();
                exp_exc = 1'b0;
            end else begin
                if (sz > 0) begin
                    check("head_result", mem_result, q[0].result);
                    check("head_pc", mem_pc, q[0].pc);
                    check("head_wdata", mem_mem_wdata, q[0].wdata);
                    check("head_reg_we", 32'(mem_reg_we), 32'(q[0].reg_we));
                    check("head_waddr", 32'(mem_reg_waddr), 32'(q[0].waddr));
                    check("head_mem_re", 32'(mem_mem_re), 32'(q[0].re));
                    check("head_mem_we", 32'(mem_mem_we), 32'(q[0].we));
                    check("head_exc_ovf", 32'(mem_exc_ovf), 32'(q[0].exc));
                    if (mem_ready) void'(q.pop_front());
                end
                trap = ex_overflow && (ex_funct == F_ADD || ex_funct == F_SUB);
                exp_exc = 1'b0;
                if (ex_valid && sz < 2) begin
                    e.result = ex_result;
                    e.pc     = ex_pc;
                    e.wdata  = ex_mem_wdata;
                    e.reg_we = ex_reg_we && !trap;
                    e.waddr  = ex_reg_waddr;
                    e.re     = ex_mem_re && !trap;
                    e.we     = ex_mem_we && !trap;
                    e.exc    = trap;
                    q.push_back(e);
                    exp_exc    = trap;
                    exp_exc_pc = ex_pc;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            mem_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [5:0] f, input logic [31:0] res, input logic ovf,
                        input logic [31:0] pc, input logic rwe, input logic [4:0] wa,
                        input logic re, input logic we, input logic [31:0] wd);
        int unsigned n = 0;
        ex_valid = 1'b1; ex_funct = f; ex_result = res; ex_overflow = ovf; ex_pc = pc;
        ex_reg_we = rwe; ex_reg_waddr = wa; ex_mem_re = re; ex_mem_we = we; ex_mem_wdata = wd;
        @(negedge clk);
        while (!ex_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; mem_ready = 1'b0;
        ex_valid = 1'b0; ex_funct = '0; ex_result = '0; ex_overflow = 1'b0; ex_pc = '0;
        ex_reg_we = 1'b0; ex_reg_waddr = '0; ex_mem_re = 1'b0; ex_mem_we = 1'b0; ex_mem_wdata = '0;
        #2 rst = 1'b0;
        #1;
        check("init_mem_valid", 32'(mem_valid), 32'd0);
        check("init_ex_ready", 32'(ex_ready), 32'd1);
        check("init_exc_req", 32'(exc_req), 32'd0);
        check("init_mem_result", mem_result, 32'd0);
        check("init_mem_reg_we", 32'(mem_reg_we), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // streaming
        mem_ready = 1'b1;
        for (int i = 1; i <= 4; i++)
            send(F_ADDU, 32'(i), 1'b0, 32'h100 + 32'(4 * i), 1'b1, 5'(i), 1'b0, 1'b0, '0);
        @(negedge clk);
        check("stream_last", mem_result, 32'd4);
        drain();

        // backpressure
        @(posedge clk); #1 mem_ready = 1'b0;
        send(F_ADDU, 32'h10, 1'b0, 32'h200, 1'b1, 5'd1, 1'b0, 1'b0, '0);
        send(F_ADDU, 32'h20, 1'b0, 32'h204, 1'b1, 5'd2, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("bp_ex_ready", 32'(ex_ready), 32'd0);
        check("bp_head", mem_result, 32'h10);
        repeat (2) @(negedge clk);
        check("bp_hold", mem_result, 32'h10);
        @(posedge clk); #1 mem_ready = 1'b1;
        @(negedge clk);
        check("bp_first", mem_result, 32'h10);
        @(negedge clk);
        check("bp_second", mem_result, 32'h20);
        check("bp_ready_back", 32'(ex_ready), 32'd1);
        drain();

        // signed overflow traps, unsigned ignored
        send(F_ADD, 32'h8000_0000, 1'b1, 32'h400, 1'b1, 5'd3, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("ovf_exc_req", 32'(exc_req), 32'd1);
        check("ovf_exc_pc", exc_pc, 32'h400);
        check("ovf_exc_flag", 32'(mem_exc_ovf), 32'd1);
        check("ovf_reg_we", 32'(mem_reg_we), 32'd0);
        @(negedge clk);
        check("ovf_pulse_end", 32'(exc_req), 32'd0);
        send(F_SUB, 32'h7fff_ffff, 1'b1, 32'h404, 1'b0, 5'd0, 1'b0, 1'b1, 32'hdead);
        @(negedge clk);
        check("sub_exc_req", 32'(exc_req), 32'd1);
        check("sub_mem_we", 32'(mem_mem_we), 32'd0);
        send(F_SUBU, 32'h7fff_ffff, 1'b1, 32'h408, 1'b1, 5'd5, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("subu_exc_req", 32'(exc_req), 32'd0);
        check("subu_reg_we", 32'(mem_reg_we), 32'd1);
        check("subu_waddr", 32'(mem_reg_waddr), 32'd5);
        check("subu_exc_flag", 32'(mem_exc_ovf), 32'd0);
        drain();

        // random traffic with random backpressure
        rand_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [5:0] f;
            case ($urandom_range(0, 4))
                0: f = F_ADD;
                1: f = F_ADDU;
                2: f = F_SUB;
                3: f = F_SUBU;
                default: f = F_AND;
            endcase
            send(f, $urandom, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom);
        end
        @(posedge clk); #1 rand_en = 1'b0;
        @(posedge clk); #1 mem_ready = 1'b1;
        drain();

        // flush in TWO with a simultaneous trapping input
        @(posedge clk); #1 mem_ready = 1'b0;
        send(F_ADDU, 32'h31, 1'b0, 32'h300, 1'b1, 5'd7, 1'b0, 1'b0, '0);
        send(F_ADDU, 32'h32, 1'b0, 32'h304, 1'b1, 5'd8, 1'b0, 1'b0, '0);
        ex_valid = 1'b1; ex_funct = F_ADD; ex_overflow = 1'b1; ex_result = 32'h55; ex_pc = 32'h500;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ex_valid = 1'b0;
        @(negedge clk);
        check("flush_mem_valid", 32'(mem_valid), 32'd0);
        check("flush_ex_ready", 32'(ex_ready), 32'd1);
        check("flush_no_exc", 32'(exc_req), 32'd0);
        @(posedge clk); #1 mem_ready = 1'b1;
        repeat (3) @(negedge clk);

        // asynchronous reset while holding one entry
        @(posedge clk); #1 mem_ready = 1'b0;
        send(F_ADDU, 32'h77, 1'b0, 32'h600, 1'b1, 5'd9, 1'b1, 1'b0, '0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_mem_valid", 32'(mem_valid), 32'd0);
        check("arst_ex_ready", 32'(ex_ready), 32'd1);
        check("arst_result", mem_result, 32'd0);
        check("arst_pc", mem_pc, 32'd0);
        check("arst_reg_we", 32'(mem_reg_we), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_result", mem_result, 32'd0);
        mem_ready = 1'b1;
        send(F_ADDU, 32'h99, 1'b0, 32'h700, 1'b1, 5'd10, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("post_rst_accept", mem_result, 32'h99);
        drain();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX→MEM pipeline stage for the TINYCPU core. It captures the execute-stage adder result, overflow flag and write-back/memory control into a two-entry skid buffer with a valid/ready handshake. It converts signed ADD/SUB overflow into a precise exception that suppresses all architectural side effects. It sits directly downstream of the EX adder and feeds the MEM stage.

## Interface
- DATA_W, 32, datapath width (matches `DATA_BUS`)
- FUNCT_W, 6, funct field width (matches `FUNCT_BUS`)
- REG_ADDR_W, 5, register-file address width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- flush  in  1  synchronous squash of all held entries
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  stage can accept; registered, depends only on state
- ex_funct  in  FUNCT_W  funct of the EX instruction
- ex_result  in  DATA_W  adder result
- ex_overflow  in  1  adder overflow flag
- ex_pc  in  DATA_W  instruction PC
- ex_reg_we / ex_reg_waddr  in  1 / REG_ADDR_W  write-back enable / address
- ex_mem_re / ex_mem_we  in  1 / 1  load / store enable
- ex_mem_wdata  in  DATA_W  store data
- mem_valid  out  1  head entry valid
- mem_ready  in  1  MEM consumes head
- mem_result, mem_pc, mem_mem_wdata  out  DATA_W  head entry fields
- mem_reg_we, mem_reg_waddr, mem_mem_re, mem_mem_we  out  head control, gated on trap
- mem_exc_ovf  out  1  head entry carries an overflow exception
- exc_req  out  1  one-cycle pulse when a trapping entry is accepted
- exc_pc  out  DATA_W  PC of that entry, valid while exc_req=1

## Operation
- accept = ex_valid & ex_ready; pop = mem_valid & mem_ready.
- Trap condition: ex_overflow & (ex_funct == `FUNCT_ADD` | ex_funct == `FUNCT_SUB`). `FUNCT_ADDU`/`FUNCT_SUBU` and all other functs ignore ex_overflow.
- On a trapping accept the stored entry has reg_we=0, mem_re=0 and mem_we=0, and exc_ovf=1. Result, PC and wdata are stored unchanged.
- Storage: main register (drives mem_* outputs) plus one skid register. Each holds every field plus exc_ovf.
- FSM states are EMPTY, ONE and TWO:
  - EMPTY: accept → ONE, loading main.
  - ONE, accept & pop: stay ONE, main ← input.
  - ONE, accept & !pop: → TWO, skid ← input.
  - ONE, !accept & pop: → EMPTY.
  - ONE, otherwise: hold.
  - TWO: pop → ONE, main ← skid. Otherwise hold. No accept possible.
- ex_ready = (state != TWO). mem_valid = (state != EMPTY).
- flush has priority over every event. Next state is EMPTY, both entries invalidated, and any same-cycle input is discarded. exc_req is not raised for a discarded input.
- Entries accepted after a trapping entry are still buffered. The controller is expected to flush them.

## Timing
- Reset: state EMPTY, ex_ready=1, mem_valid=0, exc_req=0. All data/control outputs are 0.
- Latency: accept in cycle N → mem_valid=1 with that entry in cycle N+1.
- Throughput: 1 instruction/cycle while mem_ready=1.
- While mem_valid=1 & mem_ready=0, every mem_* output holds stable.
- exc_req/exc_pc are registered. They assert in cycle N+1 for a trapping accept in cycle N, for exactly one cycle.
- Reset asserted mid-operation clears the state immediately, without waiting for clk. The first accept is possible in the first cycle after deassertion.
- Order is preserved: the skid entry always leaves after the main entry.

## Test plan
- Streaming: 4 ADDU entries, results 0x1,0x2,0x3,0x4, mem_ready=1 → results appear on consecutive cycles, one cycle after each accept; ex_ready stays 1.
- Backpressure: mem_ready=0, send A=0x10 then B=0x20 → after two accepts ex_ready=0 and mem_result holds 0x10. Raise mem_ready → 0x10 then 0x20 drain; ex_ready=1 again the cycle after the first pop.
- Signed overflow: `FUNCT_ADD`, result 0x80000000, ex_overflow=1, pc 0x400 → exc_req pulses one cycle with exc_pc 0x400; mem_exc_ovf=1 and mem_reg_we=0 on the entry.
- Unsigned ignored: `FUNCT_SUBU`, ex_overflow=1, reg_we=1, waddr 5 → no exc_req; mem_reg_we=1, mem_reg_waddr=5, mem_exc_ovf=0.
- Flush in TWO with a simultaneous ex_valid → next cycle mem_valid=0, ex_ready=1; the dropped input never appears and no exc_req is raised.
- Async reset asserted in ONE between clock edges → mem_valid drops to 0 immediately; outputs are 0 and ex_ready=1 until the next accept.
